// File: rtl/usb_audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_audio_pkg
//  Description : Shared types and constants for the USB audio playback path.
//                Holds the playback state enumeration and the default stream
//                rate constants (48 kHz audio carried in 1 ms USB frames).
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_audio_pkg;

  // Playback buffer state: FILL emits silence until enough frames are queued
  typedef enum logic {
    FILL = 1'b0,
    PLAY = 1'b1
  } play_state_t;

  localparam int c_SAMPLE_RATE_HZ        = 48000;
  localparam int c_USB_FRAMES_PER_SEC    = 1000;
  localparam int c_SAMPLES_PER_USB_FRAME = c_SAMPLE_RATE_HZ / c_USB_FRAMES_PER_SEC;

endpackage
`default_nettype wire

// File: rtl/audio_frame_ram.sv
`default_nettype none
// ============================================================================
//  Module      : audio_frame_ram
//  Description : Simple dual-port RAM, 2**AW words of DW bits. One write port
//                and one registered read port with read enable; read-first
//                behaviour when both ports address the same word.
//  Ports       : clk      - clock
//                i_we     - write enable
//                i_waddr  - write address
//                i_wdata  - write data
//                i_re     - read enable (o_rdata updates only when set)
//                i_raddr  - read address
//                o_rdata  - registered read data, held between reads
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_frame_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(2**AW)-1];
  logic [DW-1:0] r_rdata;

  // Non-blocking read of the old word makes a simultaneous write to a full
  // FIFO (write address == read address) return the head, not the new frame.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/usb_audio_play_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : usb_audio_play_buffer
//  Description : Playback frame FIFO between the USB audio streaming core and
//                the DAC. Absorbs bursty isochronous frames and releases one
//                CH x SW sample frame per DAC tick, with prefill, underrun
//                and overflow handling.
//  Ports       : clk          - system clock
//                rstn         - synchronous active-low reset
//                i_in_valid   - sample frame presented (no backpressure)
//                i_in_data    - frame, channel k at [k*SW +: SW]
//                i_out_tick   - single-cycle DAC sample strobe
//                i_flush      - clear FIFO contents, return to FILL
//                o_out_valid  - one-cycle pulse, o_out_data updated
//                o_out_data   - current DAC frame, held between pulses
//                o_level      - frames stored, 0..2**AW
//                o_playing    - high in PLAY
//                o_underrun   - pulse: tick in PLAY with FIFO empty
//                o_overflow   - pulse: input frame dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_audio_play_buffer
  import usb_audio_pkg::*;
#(
  parameter int CH      = 2,
  parameter int SW      = 16,
  parameter int AW      = 8,
  parameter int PREFILL = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_in_valid,
  input  logic [CH*SW-1:0] i_in_data,
  input  logic             i_out_tick,
  input  logic             i_flush,
  output logic             o_out_valid,
  output logic [CH*SW-1:0] o_out_data,
  output logic [AW:0]      o_level,
  output logic             o_playing,
  output logic             o_underrun,
  output logic             o_overflow
);

  localparam int          c_DW      = CH * SW;
  localparam logic [AW:0] c_PREFILL = (AW+1)'(PREFILL);

  play_state_t     r_state;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic            r_out_valid;
  logic            r_silent;
  logic            r_playing;
  logic            r_underrun;
  logic            r_overflow;

  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_write;
  logic            w_drop;
  logic [c_DW-1:0] w_rdata;

  // Level spans 0..2**AW, so its MSB alone marks a full FIFO.
  assign w_full  = r_level[AW];
  assign w_empty = (r_level == '0);

  // A flush cycle is served as FILL, so it never pops.
  assign w_pop   = (r_state == PLAY) && i_out_tick && !w_empty && !i_flush;
  assign w_write = i_in_valid && !i_flush && (!w_full || w_pop);
  assign w_drop  = i_in_valid && !i_flush && !w_write;

  audio_frame_ram #(
    .AW (AW),
    .DW (c_DW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_write),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_in_data),
    .i_re    (w_pop),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= FILL;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_silent    <= 1'b1;
      r_playing   <= 1'b0;
      r_underrun  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= i_out_tick;
      r_overflow  <= w_drop;
      r_underrun  <= 1'b0;

      // The RAM output register only moves on a pop, so it already holds the
      // last popped frame; r_silent selects between it and zero.
      if (i_out_tick) begin
        r_silent <= !w_pop;
      end

      if (i_flush) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_level   <= '0;
        r_state   <= FILL;
        r_playing <= 1'b0;
      end else begin
        if (w_write) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end

        case ({w_write, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: ;
        endcase

        case (r_state)
          FILL: begin
            if (r_level >= c_PREFILL) begin
              r_state   <= PLAY;
              r_playing <= 1'b1;
            end
          end
          PLAY: begin
            if (i_out_tick && w_empty) begin
              r_state    <= FILL;
              r_playing  <= 1'b0;
              r_underrun <= 1'b1;
            end
          end
          default: begin
            r_state   <= FILL;
            r_playing <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_silent ? '0 : w_rdata;
  assign o_level     = r_level;
  assign o_playing   = r_playing;
  assign o_underrun  = r_underrun;
  assign o_overflow  = r_overflow;

endmodule
`default_nettype wire
